partition_sweep_ctrl: RTL and testbench

Exhaustive-sweep sequencer for a combinational partition under approximation, e.g. a 7-input/4-output adder slice. On a start pulse it drives every input vector 0 … 2^NUM_IN−1 into the partition. Each cycle it compares the approximate partition's outputs against the exact reference's outputs and accumulates error metrics. It replaces the per-vector `$display` dump with on-chip counting, so approximation quality can be scored in one pass alongside the partitioned netlists.

---
 rtl/partition_sweep_pkg.sv | 27 ++
 rtl/sweep_popcount.sv | 23 ++
 rtl/partition_sweep_ctrl.sv | 124 ++++++++++++
 tb/tb_partition_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/partition_sweep_pkg.sv
// Shared types and width helpers for the partition sweep sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package partition_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  // err_cnt must hold 2^num_in, one more than the largest vector index.
  function automatic int err_cnt_width(input int num_in);
    return num_in + 1;
  endfunction

  // Width of a popcount over num_out bits.
  function automatic int pop_width(input int num_out);
    return $clog2(num_out + 1);
  endfunction

  // ham_sum must hold num_out * 2^num_in.
  function automatic int ham_sum_width(input int num_in, input int num_out);
    return num_in + $clog2(num_out + 1);
  endfunction

endpackage

// File: rtl/sweep_popcount.sv
// Purpose: combinational popcount of a WIDTH-bit vector.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
// Ports: vec (WIDTH bits in), cnt (number of set bits out).
module sweep_popcount
  import partition_sweep_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]            vec,
  output logic [pop_width(WIDTH)-1:0] cnt
);

  localparam int CW = pop_width(WIDTH);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/partition_sweep_ctrl.sv
// Purpose: drives every input vector 0..2^NUM_IN-1 into a combinational
//   partition pair and scores approximate vs exact outputs on chip.
// Latency: with step_en high, busy the cycle after start, done 2^NUM_IN+1
//   cycles after the start edge; results held until the next start.
// Backpressure: step_en low stalls the sweep one cycle at a time, losing
//   nothing; start is ignored (not queued) outside IDLE.
// Ports: clk, rst (sync, active-high), start, step_en, pi (registered
//   vector out), po_approx/po_exact (partition outputs in), busy, done,
//   err_cnt, max_abs_err, ham_sum (only with SWEEP_HAMMING_EN defined).
// Optional feature macro: SWEEP_HAMMING_EN adds the Hamming-distance total.
module partition_sweep_ctrl
  import partition_sweep_pkg::*;
#(
  parameter int NUM_IN  = 7,
  parameter int NUM_OUT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             step_en,
  output logic [NUM_IN-1:0]                pi,
  input  logic [NUM_OUT-1:0]               po_approx,
  input  logic [NUM_OUT-1:0]               po_exact,
  output logic                             busy,
  output logic                             done,
  output logic [err_cnt_width(NUM_IN)-1:0] err_cnt,
  output logic [NUM_OUT-1:0]               max_abs_err
`ifdef SWEEP_HAMMING_EN
  ,
  output logic [ham_sum_width(NUM_IN, NUM_OUT)-1:0] ham_sum
`endif
);

  localparam int EW = err_cnt_width(NUM_IN);

  sweep_state_t state_q, state_d;

  logic               accept;
  logic               eval;
  logic               last_vec;
  logic [NUM_OUT-1:0] abs_err;

  assign accept   = (state_q == IDLE) && start;
  assign eval     = (state_q == SWEEP) && step_en;
  assign last_vec = (pi == '1);

  // |approx - exact|. Taking the smaller from the larger gives the same
  // magnitude as the NUM_OUT+1-bit signed difference, and the result
  // always fits in NUM_OUT bits.
  assign abs_err = (po_approx >= po_exact) ? (po_approx - po_exact)
                                           : (po_exact - po_approx);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SWEEP;
      SWEEP:   if (step_en && last_vec) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SWEEP:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---------------- Vector counter and accumulators ----------------
  // The terminal vector is evaluated on the same edge that leaves SWEEP,
  // and pi is held there rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pi          <= '0;
      err_cnt     <= '0;
      max_abs_err <= '0;
    end else if (accept) begin
      pi          <= '0;
      err_cnt     <= '0;
      max_abs_err <= '0;
    end else if (eval) begin
      if (abs_err != '0) err_cnt <= err_cnt + EW'(1);
      if (abs_err > max_abs_err) max_abs_err <= abs_err;
      if (!last_vec) pi <= pi + NUM_IN'(1);
    end
  end

`ifdef SWEEP_HAMMING_EN
  localparam int HW = ham_sum_width(NUM_IN, NUM_OUT);

  logic [pop_width(NUM_OUT)-1:0] bit_diff;

  sweep_popcount #(
    .WIDTH (NUM_OUT)
  ) u_popcount (
    .vec (po_approx ^ po_exact),
    .cnt (bit_diff)
  );

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      ham_sum <= '0;
    end else if (eval) begin
      ham_sum <= ham_sum + HW'(bit_diff);
    end
  end
`endif

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Randomized bench for partition_sweep_ctrl: table-driven partition models,
// expected metrics computed directly from the tables over all vectors.
module tb_partition_sweep_ctrl;

  localparam int NUM_IN  = 7;
  localparam int NUM_OUT = 4;
  localparam int NV      = 1 << NUM_IN;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 step_en;
  logic [NUM_IN-1:0]    pi;
  logic [NUM_OUT-1:0]   po_approx;
  logic [NUM_OUT-1:0]   po_exact;
  logic                 busy;
  logic                 done;
  logic [NUM_IN:0]      err_cnt;
  logic [NUM_OUT-1:0]   max_abs_err;
`ifdef SWEEP_HAMMING_EN
  logic [NUM_IN+2:0]    ham_sum;
`endif

  logic [NUM_OUT-1:0] ex_tab [NV];
  logic [NUM_OUT-1:0] ap_tab [NV];

  int    n_checks = 0;
  int    n_errors = 0;
  string scen = "reset";

  int exp_err, exp_max, exp_ham;

  always #5 clk = ~clk;

  assign po_exact  = ex_tab[pi];
  assign po_approx = ap_tab[pi];

  partition_sweep_ctrl #(
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .step_en     (step_en),
    .pi          (pi),
    .po_approx   (po_approx),
    .po_exact    (po_exact),
    .busy        (busy),
    .done        (done),
    .err_cnt     (err_cnt),
    .max_abs_err (max_abs_err)
`ifdef SWEEP_HAMMING_EN
    ,
    .ham_sum     (ham_sum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0d expected %0d", scen, tag, got, exp);
    end
  endtask

  // kind 0: approx == exact; 1: approx = exact ^ 1; 2: differ only at the
  // last vector (exact F, approx 7); 3: random approximation.
  task automatic fill(input int kind);
    for (int v = 0; v < NV; v++) begin
      ex_tab[v] = NUM_OUT'($urandom_range(0, 15));
      case (kind)
        0:       ap_tab[v] = ex_tab[v];
        1:       ap_tab[v] = ex_tab[v] ^ 4'b0001;
        2:       ap_tab[v] = ex_tab[v];
        default: ap_tab[v] = ($urandom_range(0, 2) == 0) ? ex_tab[v]
                                                         : NUM_OUT'($urandom_range(0, 15));
      endcase
    end
    if (kind == 2) begin
      ex_tab[NV-1] = 4'hF;
      ap_tab[NV-1] = 4'h7;
    end
    // Reference metrics straight from the definition over every vector.
    exp_err = 0;
    exp_max = 0;
    exp_ham = 0;
    for (int v = 0; v < NV; v++) begin
      int d;
      d = int'(ap_tab[v]) - int'(ex_tab[v]);
      if (d < 0) d = -d;
      if (d != 0) exp_err++;
      if (d > exp_max) exp_max = d;
      exp_ham += $countones(ap_tab[v] ^ ex_tab[v]);
    end
  endtask

  task automatic check_metrics(input string sfx);
    chk({"err_cnt", sfx}, 32'(err_cnt), exp_err);
    chk({"max_abs_err", sfx}, 32'(max_abs_err), exp_max);
`ifdef SWEEP_HAMMING_EN
    chk({"ham_sum", sfx}, 32'(ham_sum), exp_ham);
`endif
  endtask

  // step_mode 0: always step; 1: toggle starting low; 2: random.
  // inject 0: none; 1: extra start at pi=0x10; 2: reset at pi=0x40.
  task automatic run_sweep(input int step_mode, input int inject, input int want_cycle);
    int              cyc;
    int              stalls;
    int              not_busy;
    int              dones;
    int              bad_order;
    bit              got_done;
    bit              injected;
    logic [NUM_IN-1:0] visited[$];

    cyc = 0; stalls = 0; not_busy = 0; dones = 0; bad_order = 0;
    got_done = 0; injected = 0;

    start   = 1'b1;
    step_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    chk("busy_after_start", 32'(busy), 1);
    chk("pi_after_start", 32'(pi), 0);

    while (cyc < 2000) begin
      if (done) begin
        got_done = 1;
        break;
      end
      if (!busy) not_busy++;
      case (step_mode)
        0:       step_en = 1'b1;
        1:       step_en = (cyc % 2 == 0);
        default: step_en = ($urandom_range(0, 3) != 0);
      endcase
      if (inject == 2 && busy && pi == 7'h40) begin
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_pi", 32'(pi), 0);
        chk("abort_err_cnt", 32'(err_cnt), 0);
        chk("abort_max_abs_err", 32'(max_abs_err), 0);
`ifdef SWEEP_HAMMING_EN
        chk("abort_ham_sum", 32'(ham_sum), 0);
`endif
        return;
      end
      if (inject == 1 && busy && pi == 7'h10 && !injected) begin
        start    = 1'b1;
        injected = 1;
      end
      if (busy && step_en) visited.push_back(pi);
      if (busy && !step_en) stalls++;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end

    if (!got_done) begin
      chk("done_timeout", 32'(cyc), 0);
      return;
    end
    dones = 1;
    chk("done_cycle", 32'(cyc), 129 + stalls);
    if (want_cycle > 0) chk("done_cycle_fixed", 32'(cyc), want_cycle);
    chk("busy_dropouts", 32'(not_busy), 0);
    chk("vectors_stepped", 32'(visited.size()), NV);
    foreach (visited[i]) if (int'(visited[i]) != i) bad_order++;
    chk("vector_order", 32'(bad_order), 0);
    chk("pi_held", 32'(pi), NV - 1);
    check_metrics("_at_done");

    // Single-cycle pulse, back to idle, results stable and no restart.
    step_en = 1'b1;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    repeat (4) begin
      step_en = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("done_pulses", 32'(dones), 1);
    chk("idle_busy_later", 32'(busy), 0);
    chk("idle_pi", 32'(pi), NV - 1);
    check_metrics("_idle");
  endtask

  initial begin
    for (int v = 0; v < NV; v++) begin
      ex_tab[v] = '0;
      ap_tab[v] = '0;
    end
    rst     = 1'b1;
    start   = 1'b0;
    step_en = 1'b0;
    repeat (3) @(posedge clk);
    start = 1'b1;   // must lose against reset
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pi", 32'(pi), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_max_abs_err", 32'(max_abs_err), 0);
`ifdef SWEEP_HAMMING_EN
    chk("rst_ham_sum", 32'(ham_sum), 0);
`endif
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_start", 32'(busy), 0);

    scen = "exact";       fill(0); run_sweep(0, 0, 129);
    scen = "lsb_flip";    fill(1); run_sweep(0, 0, 129);
    scen = "last_vec";    fill(2); run_sweep(0, 0, 129);
    scen = "toggle_step"; fill(0); run_sweep(1, 0, 257);
    scen = "abort";       fill(1); run_sweep(0, 2, 0);
    scen = "after_abort";          run_sweep(0, 0, 129);
    scen = "start_busy";  fill(3); run_sweep(0, 1, 129);
    for (int k = 0; k < 3; k++) begin
      scen = $sformatf("random%0d", k);
      fill(3);
      run_sweep(2, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
